// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and uart_tx-side handshake bundle for uart_tx_arbiter.
// The slave modport is the arbiter; master is the surrounding environment.
interface uart_tx_arbiter_if #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DATA_BITS = 8
);
    logic [N_REQ-1:0]           REQ_VALID;
    logic [N_REQ*DATA_BITS-1:0] REQ_DATA;
    logic [N_REQ-1:0]           REQ_ACK;
    logic [$clog2(N_REQ)-1:0]   GRANT_ID;
    logic                       ARB_BUSY;
    logic                       ERR_TIMEOUT;
    logic                       TX_DRDY;
    logic [DATA_BITS-1:0]       TX_DI;
    logic                       TX_BUSY;
    logic                       TX_DONE;

    modport master (
        output REQ_VALID, REQ_DATA, TX_BUSY, TX_DONE,
        input  REQ_ACK, GRANT_ID, ARB_BUSY, ERR_TIMEOUT, TX_DRDY, TX_DI
    );

    modport slave (
        input  REQ_VALID, REQ_DATA, TX_BUSY, TX_DONE,
        output REQ_ACK, GRANT_ID, ARB_BUSY, ERR_TIMEOUT, TX_DRDY, TX_DI
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte requesters,
// with a per-transfer timeout that aborts and acknowledges a stuck transfer.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input logic              CLK,
    input logic              RST,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned GW = $clog2(N_REQ);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LAUNCH    = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;
    localparam logic [1:0] RELEASE   = 2'd3;

    logic [1:0]           state;
    logic [GW-1:0]        ptr;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_inc;
    logic                 done_prev;
    logic                 done_rise;
    logic                 hi_found;
    logic                 lo_found;
    logic [GW-1:0]        hi_id;
    logic [GW-1:0]        lo_id;
    logic                 pick_found;
    logic [GW-1:0]        pick_id;
    logic [DATA_BITS-1:0] req_bytes [N_REQ];

    assign done_rise = bus.TX_DONE & ~done_prev;
    assign cnt_inc   = (cnt == '1) ? cnt : cnt + 1'b1;

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            req_bytes[i] = bus.REQ_DATA[i*DATA_BITS +: DATA_BITS];
        end
    end

    // Rotating scan split in two: lowest requester above the pointer wins,
    // otherwise the lowest at or below it (wrap-around).
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (bus.REQ_VALID[i]) begin
                if (GW'(i) > ptr) begin
                    if (!hi_found) begin
                        hi_found = 1'b1;
                        hi_id    = GW'(i);
                    end
                end else if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_id    = GW'(i);
                end
            end
        end
        pick_found = hi_found | lo_found;
        pick_id    = hi_found ? hi_id : lo_id;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state           <= IDLE;
            ptr             <= GW'(N_REQ - 1);
            cnt             <= '0;
            done_prev       <= 1'b0;
            bus.REQ_ACK     <= '0;
            bus.GRANT_ID    <= '0;
            bus.ARB_BUSY    <= 1'b0;
            bus.ERR_TIMEOUT <= 1'b0;
            bus.TX_DRDY     <= 1'b0;
            bus.TX_DI       <= '0;
        end else begin
            done_prev   <= bus.TX_DONE;
            bus.REQ_ACK <= '0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        bus.GRANT_ID <= pick_id;
                        bus.TX_DI    <= req_bytes[pick_id];
                        bus.TX_DRDY  <= 1'b1;
                        bus.ARB_BUSY <= 1'b1;
                        cnt          <= '0;
                        state        <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt <= cnt_inc;
                    if (bus.TX_BUSY) begin
                        bus.TX_DRDY <= 1'b0;
                        cnt         <= '0;
                        state       <= WAIT_DONE;
                    end else if (cnt >= CNT_LAST) begin
                        bus.TX_DRDY     <= 1'b0;
                        bus.ERR_TIMEOUT <= 1'b1;
                        bus.REQ_ACK     <= ONE_HOT0 << bus.GRANT_ID;
                        ptr             <= bus.GRANT_ID;
                        state           <= RELEASE;
                    end
                end
                WAIT_DONE: begin
                    cnt <= cnt_inc;
                    // A completion on the expiry cycle is a success, not an abort.
                    if (done_rise) begin
                        bus.REQ_ACK <= ONE_HOT0 << bus.GRANT_ID;
                        ptr         <= bus.GRANT_ID;
                        state       <= RELEASE;
                    end else if (cnt >= CNT_LAST) begin
                        bus.ERR_TIMEOUT <= 1'b1;
                        bus.REQ_ACK     <= ONE_HOT0 << bus.GRANT_ID;
                        ptr             <= bus.GRANT_ID;
                        state           <= RELEASE;
                    end
                end
                RELEASE: begin
                    bus.ARB_BUSY <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    bus.TX_DRDY  <= 1'b0;
                    bus.ARB_BUSY <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx instance between N_REQ byte requesters using round-robin arbitration. It latches the granted byte and drives the uart_tx TX_DRDY/TX_DI handshake. It waits for TX_BUSY and then TX_DONE, and acknowledges the requester once its byte has been fully serialized. It sits between application logic (button/app sequencers, loggers) and the uart_tx/baud_generator pair.

Parameters:
N_REQ, 4, number of requesters (2..16)
DATA_BITS, 8, byte width; must match uart_tx DATA_BITS
TIMEOUT_CYCLES, 20000, CLK cycles allowed in LAUNCH or WAIT_DONE before abort (> one frame at 115200 baud / 100 MHz = 8680)

Ports:
CLK  in  1  system clock; all logic on posedge
RST  in  1  synchronous, active-high reset
REQ_VALID  in  N_REQ  per-requester request; held high with stable data until REQ_ACK
REQ_DATA  in  N_REQ*DATA_BITS  requester i byte at [i*DATA_BITS +: DATA_BITS]
REQ_ACK  out  N_REQ  one-cycle pulse to the granted requester when its byte completes or is aborted
GRANT_ID  out  $clog2(N_REQ)  index of the current or last granted requester
ARB_BUSY  out  1  high in any state other than IDLE
ERR_TIMEOUT  out  1  sticky; set on an aborted transfer, cleared only by RST
TX_DRDY  out  1  to uart_tx TX_DRDY
TX_DI  out  DATA_BITS  to uart_tx TX_DI
TX_BUSY  in  1  from uart_tx
TX_DONE  in  1  from uart_tx

Behaviour:
- Reset (RST=1 at posedge):
  - State = IDLE.
  - REQ_ACK=0, TX_DRDY=0, TX_DI=0, GRANT_ID=0, ARB_BUSY=0, ERR_TIMEOUT=0.
  - Round-robin pointer = N_REQ-1, so requester 0 has top priority first.
  - Timeout counter = 0; done_prev = 0.
  - RST mid-transfer abandons the transfer with no ACK. The uart_tx frame already in flight is not this block's concern.
- All outputs are registered.
- TX_DONE is edge-detected: done_rise = TX_DONE & ~done_prev, with done_prev registered every cycle.
- FSM states: IDLE, LAUNCH, WAIT_DONE, RELEASE.
- IDLE:
  - If REQ_VALID != 0, pick the first set bit scanning from pointer+1 upward, wrapping modulo N_REQ.
  - Latch GRANT_ID, latch TX_DI = that requester's slice, set TX_DRDY=1, clear the counter, go to LAUNCH.
  - Grant-to-TX_DRDY latency is 1 cycle after REQ_VALID is sampled.
- LAUNCH:
  - Hold TX_DRDY=1 and TX_DI stable. Counter increments each cycle.
  - When TX_BUSY=1 is sampled: TX_DRDY<=0, counter<=0, go to WAIT_DONE.
  - Counter reaching TIMEOUT_CYCLES-1 takes the abort path.
- WAIT_DONE:
  - TX_DRDY=0. Counter increments each cycle.
  - On done_rise: REQ_ACK[GRANT_ID]<=1 for one cycle, pointer<=GRANT_ID, go to RELEASE.
  - Counter reaching TIMEOUT_CYCLES-1 takes the abort path.
- Abort path (from LAUNCH or WAIT_DONE):
  - TX_DRDY<=0, ERR_TIMEOUT<=1, REQ_ACK[GRANT_ID] pulses, pointer<=GRANT_ID, go to RELEASE.
- RELEASE: one cycle with REQ_ACK=0, then go to IDLE. This gives the requester one cycle to drop REQ_VALID, so a stale request is never re-granted.
- Fairness: a requester holding REQ_VALID continuously while others request is served at most once per N_REQ grants.
- A single active requester is served back-to-back. Bytes are separated by ≥3 CLK cycles plus whatever uart_tx inserts.
- REQ_VALID changes while the block is not in IDLE are ignored. Data is taken only at grant time.
- done_rise arriving in the same cycle as a timeout expiry counts as success: ACK pulses, ERR_TIMEOUT unchanged.
- done_rise sampled in IDLE, LAUNCH or RELEASE is ignored.
- Counter width is $clog2(TIMEOUT_CYCLES)+1 and it saturates, never wraps.

Test Plan:
- Single requester: RST pulse, then REQ_VALID=4'b0001 with byte 0xA5. Required: TX_DRDY rises 1 cycle later with TX_DI=0xA5; the serial line decodes 0xA5; REQ_ACK[0] pulses once after TX_DONE; ARB_BUSY returns to 0.
- Contention: REQ_VALID=4'b1111 continuously with bytes 0x10/0x21/0x32/0x43. Required grant order 0,1,2,3,0,1 and the decoded bytes in that order. Each REQ_ACK pulse is exactly one cycle wide.
- Fairness wrap: after requester 2 is served, REQ_VALID=4'b0101. Required: next grant is 0, then 2.
- Timeout: tie TX_BUSY=0 with REQ_VALID=4'b0010. Required: after 20000 cycles TX_DRDY drops, ERR_TIMEOUT=1 and stays high, REQ_ACK[1] pulses, and the block returns to IDLE.
- Reset mid-frame: assert RST for 1 cycle in WAIT_DONE. Required: all outputs reach their reset values the next cycle, no REQ_ACK pulse, and the next grant goes to requester 0 first.
- Simultaneous events: force TX_DONE's rising edge on the exact cycle the counter expires. Required: REQ_ACK pulses and ERR_TIMEOUT stays 0.
